mole_game_ctrl: RTL and testbench

//  Game sequencer for whack-a-mole. Owns the round timer and loads a PRBS pattern

---
 rtl/mole_game_ctrl.sv | 111 +++++++++++
 tb/tb_mole_game_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole sequencer: loads a PRBS pattern onto the mole LEDs each round, scores switch
// toggles as hits or misses, and ends the game after a fixed number of rounds.
module mole_game_ctrl #(
   parameter int unsigned N_MOLES         = 10,
   parameter int unsigned TICKS_PER_ROUND = 50_000_000,
   parameter int unsigned NUM_ROUNDS      = 30,
   parameter int unsigned SCORE_W         = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_MOLES-1:0] random,
   input  logic [N_MOLES-1:0] switch,
   output logic [N_MOLES-1:0] moles,
   output logic [SCORE_W-1:0] score,
   output logic [5:0]         round,
   output logic               round_tick,
   output logic               busy,
   output logic               game_over
);

   localparam int unsigned CNT_W = (TICKS_PER_ROUND > 1) ? $clog2(TICKS_PER_ROUND) : 1;
   localparam int unsigned DW    = SCORE_W + 2;
   localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(TICKS_PER_ROUND - 1);
   localparam logic [5:0]           LAST_ROUND = 6'(NUM_ROUNDS - 1);
   localparam logic signed [DW-1:0] SCORE_MAX  = {2'b00, {SCORE_W{1'b1}}};

   typedef enum logic [2:0] {StIdle, StLoad, StShow, StRoundEnd, StGameOver} state_t;

   state_t                 state;
   logic [N_MOLES-1:0]     sw_q;
   logic [N_MOLES-1:0]     tog, hit, miss, remain;
   logic [CNT_W-1:0]       count;
   logic signed [DW-1:0]   score_sum, score_sat;

   function automatic logic [DW-1:0] popcnt(input logic [N_MOLES-1:0] v);
      logic [DW-1:0] c;
      c = '0;
      for (int i = 0; i < int'(N_MOLES); i++) c = c + DW'(v[i]);
      return c;
   endfunction

   // Sampled in every state, reset included, so no stale toggle appears after reset.
   always_ff @(posedge clk) sw_q <= switch;

   always_comb begin
      tog       = switch ^ sw_q;
      hit       = tog & moles;
      miss      = tog & ~moles;
      remain    = moles & ~hit;
      score_sum = $signed({2'b00, score}) + $signed(popcnt(hit)) - $signed(popcnt(miss));
      if (score_sum < 0)              score_sat = '0;
      else if (score_sum > SCORE_MAX) score_sat = SCORE_MAX;
      else                            score_sat = score_sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         moles      <= '0;
         score      <= '0;
         round      <= '0;
         count      <= '0;
         round_tick <= 1'b0;
      end else begin
         round_tick <= 1'b0;
         unique case (state)
            StIdle: begin
               moles <= '0;
               if (start) begin
                  state <= StLoad;
                  score <= '0;
                  round <= '0;
                  count <= '0;
               end
            end
            StLoad: begin
               moles <= (random == '0) ? N_MOLES'(1) : random;
               count <= '0;
               state <= StShow;
            end
            StShow: begin
               count <= count + 1'b1;
               moles <= remain;
               score <= score_sat[SCORE_W-1:0];
               if (count == CNT_LAST || remain == '0) begin
                  state      <= StRoundEnd;
                  round_tick <= 1'b1;
               end
            end
            StRoundEnd: begin
               round <= round + 6'd1;
               state <= (round == LAST_ROUND) ? StGameOver : StLoad;
            end
            StGameOver: begin
               moles <= '0;
               if (start) begin
                  state <= StLoad;
                  score <= '0;
                  round <= '0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign busy      = (state == StLoad) || (state == StShow) || (state == StRoundEnd);
   assign game_over = (state == StGameOver);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Randomized scoreboard bench for mole_game_ctrl; a second instance with a 4-bit score
// makes saturation reachable within a short game.
module tb_mole_game_ctrl;
   localparam int N  = 10;
   localparam int T  = 8;
   localparam int NR = 3;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [N-1:0] random, switch;
   logic [N-1:0] moles_a, moles_b;
   logic [7:0]   score_a;
   logic [3:0]   score_b;
   logic [5:0]   round_a, round_b;
   logic         tick_a, tick_b, busy_a, busy_b, over_a, over_b;

   always #5 clk = ~clk;

   mole_game_ctrl #(.N_MOLES(N), .TICKS_PER_ROUND(T), .NUM_ROUNDS(NR), .SCORE_W(8)) dut_a (
      .clk(clk), .rst(rst), .start(start), .random(random), .switch(switch),
      .moles(moles_a), .score(score_a), .round(round_a), .round_tick(tick_a),
      .busy(busy_a), .game_over(over_a));

   mole_game_ctrl #(.N_MOLES(N), .TICKS_PER_ROUND(T), .NUM_ROUNDS(NR), .SCORE_W(4)) dut_b (
      .clk(clk), .rst(rst), .start(start), .random(random), .switch(switch),
      .moles(moles_b), .score(score_b), .round(round_b), .round_tick(tick_b),
      .busy(busy_b), .game_over(over_b));

   typedef struct packed {
      logic [9:0] moles;
      logic [7:0] score_a;
      logic [3:0] score_b;
      logic [5:0] round;
      logic       tick;
      logic       busy;
      logic       over;
   } exp_t;

   exp_t exp_q[$];
   exp_t e, got;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: game phase plus plain integer bookkeeping.
   localparam int PH_IDLE = 0, PH_LOAD = 1, PH_SHOW = 2, PH_END = 3, PH_OVER = 4;
   int           ph = PH_IDLE;
   logic [N-1:0] m_moles = '0;
   logic [N-1:0] m_sw = '0;
   int           m_sa = 0, m_sb = 0, m_round = 0, m_count = 0;
   bit           m_tick = 1'b0;

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   task automatic model_step();
      logic [N-1:0] tog, hit, miss;
      int d;
      exp_t x;
      tog  = switch ^ m_sw;
      m_sw = switch;
      m_tick = 1'b0;
      if (rst) begin
         ph = PH_IDLE; m_moles = '0; m_sa = 0; m_sb = 0; m_round = 0; m_count = 0;
      end else begin
         case (ph)
            PH_IDLE: begin
               m_moles = '0;
               if (start) begin ph = PH_LOAD; m_sa = 0; m_sb = 0; m_round = 0; m_count = 0; end
            end
            PH_LOAD: begin
               m_moles = (random != 0) ? random : 10'd1;
               m_count = 0;
               ph = PH_SHOW;
            end
            PH_SHOW: begin
               hit  = tog & m_moles;
               miss = tog & ~m_moles;
               d = $countones(hit) - $countones(miss);
               m_sa = clampi(m_sa + d, 255);
               m_sb = clampi(m_sb + d, 15);
               m_moles = m_moles & ~hit;
               if (m_count == T - 1 || m_moles == 0) begin ph = PH_END; m_tick = 1'b1; end
               m_count++;
            end
            PH_END: begin
               m_round++;
               ph = (m_round == NR) ? PH_OVER : PH_LOAD;
            end
            default: begin
               m_moles = '0;
               if (start) begin ph = PH_LOAD; m_sa = 0; m_sb = 0; m_round = 0; end
            end
         endcase
      end
      x = {m_moles, 8'(m_sa), 4'(m_sb), 6'(m_round), m_tick,
           (ph == PH_LOAD || ph == PH_SHOW || ph == PH_END), (ph == PH_OVER)};
      exp_q.push_back(x);
   endtask

   // Monitor: one expected entry per clock edge, checked just after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {moles_a, score_a, score_b, round_a, tick_a, busy_a, over_a};
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL outputs t=%0t got moles=%h sa=%0d sb=%0d round=%0d tick=%b busy=%b over=%b exp moles=%h sa=%0d sb=%0d round=%0d tick=%b busy=%b over=%b",
                     $time, got.moles, got.score_a, got.score_b, got.round, got.tick, got.busy,
                     got.over, e.moles, e.score_a, e.score_b, e.round, e.tick, e.busy, e.over);
         end
      end
   end

   initial begin
      int r, j;
      bit quiet, done;
      rst = 1'b1; start = 1'b0; random = '0; switch = '0;
      model_step();
      @(negedge clk);
      model_step();
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         quiet  = ((c / 150) % 3) == 0;
         rst    = ($urandom_range(0, 299) == 0);
         start  = ($urandom_range(0, 5) == 0);
         random = ($urandom_range(0, 3) == 0) ? '0 : 10'($urandom);
         r = $urandom_range(0, 99);
         if (quiet) begin
            if (r < 4) switch[$urandom_range(0, N - 1)] = ~switch[$urandom_range(0, N - 1)];
         end else if (r < 45 && m_moles != 0) begin
            j = $urandom_range(0, N - 1);
            done = 1'b0;
            for (int k = 0; k < N; k++) begin
               if (!done && m_moles[(j + k) % N]) begin
                  switch[(j + k) % N] = ~switch[(j + k) % N];
                  done = 1'b1;
               end
            end
         end else if (r < 55) begin
            switch[$urandom_range(0, N - 1)] = ~switch[$urandom_range(0, N - 1)];
         end else if (r < 60) begin
            switch = switch ^ 10'($urandom);
         end
         model_step();
      end
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending entries exp 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
